baud_generator: RTL and testbench
=================================

# baud_generator

Programmable baud-rate tick generator for the SPART/UART datapath. It sits directly upstream of the receive control, which consumes its single-cycle `baud` enable to clock the receive shift register and bit timer; the transmit side consumes the 1x `tx_baud` enable. The divisor is loaded byte-wise over the processor I/O bus and committed atomically.

## Interface
- `DIV_W`, 16: divisor width in bits; fixed to two bus bytes.
- `RESET_DIVISOR`, 16'd325: divisor after reset (50 MHz / (9600 × 16)).
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset; asynchronous, active-high.
- `iocs` input 1: chip select for the I/O bus.
- `iorw` input 1: 1 = read, 0 = write; only writes affect this block.
- `ioaddr` input 2: 2'b10 = divisor low byte (DB_LO), 2'b11 = divisor high byte (DB_HI); other addresses are ignored.
- `databus_in` input 8: write data.
- `baud` output 1: one-cycle sample enable to receive control. Its rate is 16x with oversampling compiled in, 1x otherwise.
- `tx_baud` output 1: one-cycle 1x bit enable to transmit control.
- `divisor` output 16: committed divisor for readback muxing.
- `running` output 1: high when `divisor` is non-zero.

## Operation
- **Registers:**
  - `lo_stage[7:0]`: staged low byte.
  - `div_q[15:0]`: committed divisor.
  - `cnt[15:0]`: down-counter.
  - `os_cnt[3:0]`: oversample phase.
- **Writes** are qualified by `iocs & ~iorw`.
  - DB_LO: `lo_stage <= databus_in`. There is no effect on the running rate.
  - DB_HI: commit. `div_q <= {databus_in, lo_stage}`, `cnt <= {databus_in, lo_stage} - 1`, `os_cnt <= 0`.
- **States:**
  - HALT: `div_q == 0`. Counters hold at 0 and no enables are produced.
  - RUN: `div_q != 0`.
  - The only transitions are commits, plus reset, which enters RUN.
- **RUN counting:**
  - If `cnt == 0`, reload `div_q - 1` and assert `baud`; otherwise decrement.
  - `baud = running & (cnt == 0)`. It is decoded from flops and is glitch-free.
  - On each `baud`, `os_cnt` increments with a 4-bit wrap.
  - `tx_baud = baud & (os_cnt == 15)`.
- **Reset values:**
  - `lo_stage = RESET_DIVISOR[7:0]`, `div_q = RESET_DIVISOR`, `cnt = RESET_DIVISOR - 1`, `os_cnt = 0`.
  - `baud = 0` unless `RESET_DIVISOR == 1`.
  - `tx_baud = 0`, `running = 1`.
- **Boundaries:**
  - Divisor 1: `baud` is high every cycle.
  - Divisor 0: HALT, with `baud` and `tx_baud` held low.
  - A commit in the same cycle as `cnt == 0`: the commit wins. `baud` is still asserted in that cycle (old period completes) and the new load replaces the reload.
  - Reads and non-selected cycles have no effect.
  - Reset asserted mid-count restores all reset values immediately; no partial tick is emitted.

## Timing
- A commit in cycle N sets `cnt = D-1` at cycle N+1. The first new `baud` is in cycle N+D, then every D cycles.
- The `baud` period is D cycles. The `tx_baud` period is 16·D cycles, and the first `tx_baud` after a commit is in cycle N+16·D.
- `divisor` and `running` update one cycle after the commit write.
- Zero-latency combinational path: none from bus inputs to `baud`/`tx_baud`.

## Configuration
- `BAUD_OVERSAMPLE_EN`:
  - Defined: behaviour as above; `baud` runs 16x and `tx_baud` fires on `os_cnt == 15`.
  - Undefined: `os_cnt` is removed, `tx_baud = baud`, and both run at 1x with period D.

## Structure
- **Shared package `spart_pkg`:**
  - `ADDR_DB_LO = 2'b10`, `ADDR_DB_HI = 2'b11`.
  - `OVERSAMPLE = 16`.
  - `RESET_DIVISOR` default.
  - `typedef enum {HALT, RUN} baud_state_t`.
- **Sub-module `baud_div_counter`:** the reloadable down-counter with load, reload and tick. It is reused by transmit timing.

## Test plan
- **Reset:** release `rst` with the default divisor 325 → `divisor = 325`, `running = 1`, first `baud` 325 cycles after release, `tx_baud` after 5200 cycles.
- **Byte-wise load:** write DB_LO = 0x04, wait 100 cycles → the rate is unchanged. Then write DB_HI = 0x00 → `baud` every 4 cycles, starting 4 cycles after the commit; `tx_baud` every 64 cycles.
- **Divisor 1:** commit 0x0001 → `baud` high every cycle; `tx_baud` every 16th cycle.
- **Divisor 0:** commit 0x0000 → `running = 0`, no `baud`/`tx_baud` for 1000 cycles. Recommit 0x0002 → ticks resume at period 2.
- **Commit collision:** commit 0x0003 in the same cycle as a `cnt == 0` tick → `baud` is asserted that cycle, then the next tick arrives exactly 3 cycles later.
- **Mid-count reset:** pulse `rst` at `cnt = 100` with divisor 325 → all reset values are restored and the next `baud` is 325 cycles after release. Without `BAUD_OVERSAMPLE_EN`, `tx_baud == baud` every cycle.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART constants and types: I/O bus addresses, oversample ratio,
// default divisor, baud generator state encoding and the bus write payload.
package spart_pkg;

  localparam logic [1:0] ADDR_DB_LO = 2'b10;
  localparam logic [1:0] ADDR_DB_HI = 2'b11;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned OS_W       = 4;

  // 50 MHz / (9600 * 16)
  localparam logic [15:0] RESET_DIVISOR = 16'd325;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } baud_state_t;

  // Payload of one I/O bus write as seen by this block
  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } io_wr_t;

endpackage

// File: rtl/baud_div_counter.sv
// Reloadable down-counter producing a one-cycle tick on terminal count.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   en          - count enable; when low the counter holds and no tick is produced
//   load        - load load_val (takes priority over counting and reload)
//   load_val    - value loaded on load
//   reload_val  - value reloaded when the count reaches zero
//   tick_c      - decoded from the count flop: en & (cnt == 0)
module baud_div_counter #(
  parameter int unsigned   W         = 16,
  parameter logic [W-1:0]  RESET_CNT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] reload_val,
  output logic         tick_c
);

  logic [W-1:0] cnt;

  // Load wins over the terminal-count reload so a new period starts cleanly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RESET_CNT;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (cnt == '0) ? reload_val : cnt - W'(1);
    end
  end

  assign tick_c = en & (cnt == '0);

endmodule

// File: rtl/baud_generator.sv
// Programmable baud-rate tick generator. The divisor is staged byte-wise over
// the I/O bus (low byte first) and committed atomically by the high-byte write.
// Compile option: BAUD_OVERSAMPLE_EN - baud runs at 16x the bit rate and
// tx_baud fires on every 16th baud; otherwise tx_baud == baud at 1x.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   iocs, iorw   - bus chip select, 1 = read / 0 = write
//   ioaddr       - 2'b10 divisor low byte, 2'b11 divisor high byte (commit)
//   databus_in   - write data
//   baud         - one-cycle sample enable to receive control
//   tx_baud      - one-cycle 1x bit enable to transmit control
//   divisor      - committed divisor
//   running      - committed divisor is non-zero
module baud_generator #(
  parameter int unsigned       DIV_W         = 16,
  parameter logic [DIV_W-1:0]  RESET_DIVISOR = spart_pkg::RESET_DIVISOR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iocs,
  input  logic             iorw,
  input  logic [1:0]       ioaddr,
  input  logic [7:0]       databus_in,
  output logic             baud,
  output logic             tx_baud,
  output logic [DIV_W-1:0] divisor,
  output logic             running
);

  import spart_pkg::*;

  localparam logic [DIV_W-1:0] RESET_CNT =
    (RESET_DIVISOR == '0) ? '0 : RESET_DIVISOR - DIV_W'(1);
  localparam baud_state_t RESET_STATE =
    (RESET_DIVISOR == '0) ? HALT : RUN;

  io_wr_t           wr;
  logic             wr_en;
  logic             wr_lo;
  logic             commit;
  logic [7:0]       lo_stage;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] commit_val;
  logic [DIV_W-1:0] load_val;
  logic [DIV_W-1:0] reload_val;
  baud_state_t      state_q;
  baud_state_t      state_d;
  logic             tick_c;

  // Bus write decode; reads and deselected cycles do nothing
  assign wr         = '{addr: ioaddr, data: databus_in};
  assign wr_en      = iocs & ~iorw;
  assign wr_lo      = wr_en & (wr.addr == ADDR_DB_LO);
  assign commit     = wr_en & (wr.addr == ADDR_DB_HI);
  assign commit_val = {wr.data, lo_stage};

  // A zero commit parks the counter at 0 rather than wrapping to all-ones
  assign load_val   = (commit_val == '0) ? '0 : commit_val - DIV_W'(1);
  assign reload_val = div_q - DIV_W'(1);

  // Next state: only a commit moves between HALT and RUN
  always_comb begin
    state_d = state_q;
    if (commit) begin
      state_d = (commit_val != '0) ? RUN : HALT;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Staged low byte and committed divisor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_stage <= RESET_DIVISOR[7:0];
      div_q    <= RESET_DIVISOR;
    end else begin
      if (wr_lo) begin
        lo_stage <= wr.data;
      end
      if (commit) begin
        div_q <= commit_val;
      end
    end
  end

  assign divisor = div_q;
  assign running = (state_q == RUN);

  baud_div_counter #(
    .W         (DIV_W),
    .RESET_CNT (RESET_CNT)
  ) u_div_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (running),
    .load       (commit),
    .load_val   (load_val),
    .reload_val (reload_val),
    .tick_c     (tick_c)
  );

  assign baud = tick_c;

`ifdef BAUD_OVERSAMPLE_EN
  logic [OS_W-1:0] os_cnt;

  // Oversample phase; a commit restarts the 16-tick bit frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt <= '0;
    end else if (commit) begin
      os_cnt <= '0;
    end else if (tick_c) begin
      os_cnt <= os_cnt + OS_W'(1);
    end
  end

  assign tx_baud = tick_c & (os_cnt == OS_W'(OVERSAMPLE - 1));
`else
  assign tx_baud = tick_c;
`endif

endmodule

// File: tb/tb_baud_generator.sv
// Self-checking bench for baud_generator. Every cycle is compared against a
// reference model that tracks the committed divisor and the time elapsed since
// the last commit: a tick is due whenever that time is a positive multiple of
// the divisor, and a bit enable on every 16th tick when oversampling is built.
module tb_baud_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        iocs;
  logic        iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  databus_in;
  logic        baud;
  logic        tx_baud;
  logic [15:0] divisor;
  logic        running;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_div;
  int m_e;
  int m_lo;

  localparam logic [1:0] A_LO = 2'b10;
  localparam logic [1:0] A_HI = 2'b11;

  typedef struct {
    bit          cs;
    bit          rw;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_div;
    bit          exp_run;
  } vec_t;

  vec_t tbl[9];

  baud_generator dut (
    .clk        (clk),
    .rst        (rst),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus_in (databus_in),
    .baud       (baud),
    .tx_baud    (tx_baud),
    .divisor    (divisor),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare this cycle against the model, then advance the model across the
  // coming rising edge using the bus inputs currently driven.
  task automatic step();
    bit exp_b;
    bit exp_t;
    exp_b = (m_div != 0) && (m_e > 0) && ((m_e % m_div) == 0);
`ifdef BAUD_OVERSAMPLE_EN
    exp_t = exp_b && (((m_e / m_div) % 16) == 0);
`else
    exp_t = exp_b;
`endif
    chk("baud",    32'(baud),    32'(exp_b));
    chk("tx_baud", 32'(tx_baud), 32'(exp_t));
    chk("divisor", 32'(divisor), 32'(m_div));
    chk("running", 32'(running), 32'(m_div != 0));
    if (iocs && !iorw) begin
      if (ioaddr == A_LO) begin
        m_lo = int'(databus_in);
      end else if (ioaddr == A_HI) begin
        m_div = int'(databus_in) * 256 + m_lo;
        m_e   = 0;
      end
    end
    m_e++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    iocs = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus(input bit cs, input bit rw, input logic [1:0] addr, input logic [7:0] data);
    iocs = cs; iorw = rw; ioaddr = addr; databus_in = data;
    step();
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic commit(input logic [15:0] val);
    bus(1'b1, 1'b0, A_LO, val[7:0]);
    bus(1'b1, 1'b0, A_HI, val[15:8]);
  endtask

  // Cycles from the current one until baud is seen, 1-based, bounded
  task automatic gap_to_tick(input string name, input int expected);
    int n;
    n = 1;
    while (!baud && n < 2000) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'(expected));
  endtask

  // Pulse reset (model frozen while held), checking values during reset
  task automatic do_reset();
    iocs = 1'b0;
    rst  = 1'b1;
    #1;
    chk("rst_divisor", 32'(divisor), 32'd325);
    chk("rst_running", 32'(running), 32'd1);
    chk("rst_baud",    32'(baud),    32'd0);
    chk("rst_tx_baud", 32'(tx_baud), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_baud", 32'(baud), 32'd0);
    rst   = 1'b0;
    m_div = 325;
    m_lo  = 8'h45;
    // Reset behaves like a commit one cycle earlier: count starts at D-1
    m_e   = 1;
  endtask

  initial begin
    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; databus_in = 8'h00;
    m_div = 325; m_lo = 8'h45; m_e = 1;

    tbl[0] = '{1'b1, 1'b0, A_LO,  8'h10, 16'h0145, 1'b1}; // stage only
    tbl[1] = '{1'b1, 1'b1, A_HI,  8'h00, 16'h0145, 1'b1}; // read ignored
    tbl[2] = '{1'b0, 1'b0, A_HI,  8'h00, 16'h0145, 1'b1}; // deselected
    tbl[3] = '{1'b1, 1'b0, 2'b00, 8'h00, 16'h0145, 1'b1}; // other address
    tbl[4] = '{1'b1, 1'b0, A_HI,  8'h00, 16'h0010, 1'b1}; // commit 0x0010
    tbl[5] = '{1'b1, 1'b0, A_LO,  8'h00, 16'h0010, 1'b1};
    tbl[6] = '{1'b1, 1'b0, A_HI,  8'h00, 16'h0000, 1'b0}; // commit 0 -> halt
    tbl[7] = '{1'b1, 1'b0, A_LO,  8'h07, 16'h0000, 1'b0};
    tbl[8] = '{1'b1, 1'b0, A_HI,  8'h00, 16'h0007, 1'b1}; // resume at 7

    @(negedge clk);
    do_reset();

    // Default divisor: first baud at the 325th count, tx_baud by 5200
    gap_to_tick("reset_first_baud", 325);
    idle(5300);

    // Bus decode table
    for (int i = 0; i < 9; i++) begin
      bus(tbl[i].cs, tbl[i].rw, tbl[i].addr, tbl[i].data);
      chk($sformatf("tbl%0d_divisor", i), 32'(divisor), 32'(tbl[i].exp_div));
      chk($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].exp_run));
    end
    idle(200);

    // Staged low byte leaves the rate alone until the high byte commits
    bus(1'b1, 1'b0, A_LO, 8'h04);
    idle(100);
    bus(1'b1, 1'b0, A_HI, 8'h00);
    gap_to_tick("div4_first_baud", 4);
    idle(200);

    // Divisor 1: baud every cycle
    commit(16'h0001);
    idle(64);
    chk("div1_baud", 32'(baud), 32'd1);

    // Divisor 0: halt, then resume at period 2
    commit(16'h0000);
    idle(1000);
    chk("halt_running", 32'(running), 32'd0);
    commit(16'h0002);
    idle(40);

    // Commit collides with a terminal-count tick
    bus(1'b1, 1'b0, A_LO, 8'h03);
    begin
      int guard;
      guard = 0;
      while (!baud && guard < 10) begin
        step();
        guard++;
      end
    end
    chk("collision_tick", 32'(baud), 32'd1);
    bus(1'b1, 1'b0, A_HI, 8'h00);
    gap_to_tick("collision_gap", 3);
    idle(100);

    // Reset at cnt == 100 with divisor 325
    commit(16'd325);
    idle(224);
    do_reset();
    gap_to_tick("midreset_first_baud", 325);
    idle(50);

    // Random bus traffic with small divisors
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        logic [1:0] a;
        logic [7:0] d;
        a = 2'($urandom_range(0, 3));
        if (a == A_HI) d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
        else           d = 8'($urandom_range(0, 15));
        bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      end else begin
        idle(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
